// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the show-ahead read port of an async FIFO into a
// registered valid/ready stream through a 2-entry skid buffer. rinc depends
// only on registered occupancy, enable and rempty, never on m_ready. Also
// counts FIFO pops modulo 2^CNTW.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             enable,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNTW-1:0]  pop_cnt,
    output logic             idle
);

    // Buffer occupancy; head feeds m_data, skid holds the second word
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DSIZE-1:0] head;
    logic [DSIZE-1:0] head_nxt;
    logic [DSIZE-1:0] skid;
    logic [DSIZE-1:0] skid_nxt;
    logic             push;
    logic             pop;

    // Reset is folded in so no pop can be issued while the buffer is cleared
    assign rinc    = rrst_n & enable & ~rempty & (state != TWO);
    assign push    = rinc;
    assign pop     = m_valid & m_ready;
    assign m_valid = (state != EMPTY);
    assign m_data  = head;
    assign idle    = (state == EMPTY) & rempty;

    // Next occupancy and storage moves; TWO never sees a push
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        case (state)
            EMPTY: begin
                if (push) begin
                    head_nxt  = rdata;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_nxt = rdata;
                end else if (push) begin
                    skid_nxt  = rdata;
                    state_nxt = TWO;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_nxt  = skid;
                    state_nxt = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Occupancy and storage registers; reset discards any buffered words
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            skid  <= skid_nxt;
        end
    end

    // Running pop count, wraps naturally at 2^CNTW
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pop_cnt <= '0;
        end else if (push) begin
            pop_cnt <= pop_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, a
// word-level model (queue of popped-but-undelivered words) predicts every
// output each cycle, and directed scenarios pin the results with literals.
// A second instance with CNTW=4 shares the inputs to exercise counter wrap.
module tb_fifo_rd_stream;

    logic        rclk;
    logic        rrst_n;
    logic [7:0]  rdata;
    logic        rempty;
    logic        enable;
    logic        m_ready;
    logic        rinc;
    logic [7:0]  m_data;
    logic        m_valid;
    logic [15:0] pop_cnt;
    logic        idle;
    logic        rinc4;
    logic [7:0]  m_data4;
    logic        m_valid4;
    logic [3:0]  pop_cnt4;
    logic        idle4;

    fifo_rd_stream #(.DSIZE(8), .CNTW(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
        .rinc(rinc), .enable(enable), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .pop_cnt(pop_cnt), .idle(idle)
    );

    fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
        .rinc(rinc4), .enable(enable), .m_data(m_data4), .m_valid(m_valid4),
        .m_ready(m_ready), .pop_cnt(pop_cnt4), .idle(idle4)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] fq[$];    // FIFO contents, head at index 0
    logic [7:0] mq[$];    // model: words popped but not yet delivered
    logic [7:0] dlv[$];   // words the DUT actually handed downstream
    logic [7:0] last_w;   // model: last delivered word (head when empty)
    int         m_cnt;    // model: pops since reset
    logic       pop_s;
    int         occ;
    logic       e_rinc;
    logic [7:0] e_data;
    int         run_len;
    int         max_run;

    function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function void refresh();
        rempty = (fq.size() == 0);
        rdata  = rempty ? 8'h00 : fq[0];
    endfunction

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
        refresh();
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge rclk);
        #2;
    endtask

    task automatic chk_dlv(input string nm, input logic [7:0] first, input int n);
        chk({nm, "_count"}, dlv.size(), n);
        for (int i = 0; i < n; i++)
            chk(nm, (i < dlv.size()) ? dlv[i] : 8'hxx, first + 8'(i));
    endtask

    // FIFO advances just after the edge on which a pop was sampled
    always @(posedge rclk) begin
        #1;
        if (pop_s && fq.size() > 0) void'(fq.pop_front());
        refresh();
    end

    // Per-cycle compare against the word-level model, then advance the model
    always @(negedge rclk) begin
        if (!rrst_n) begin
            mq.delete();
            m_cnt  = 0;
            last_w = 8'h00;
        end
        occ    = mq.size();
        e_rinc = rrst_n && enable && !rempty && (occ < 2);
        e_data = (occ > 0) ? mq[0] : last_w;
        chk("rinc", rinc, e_rinc);
        chk("m_valid", m_valid, occ > 0);
        chk("m_data", m_data, e_data);
        chk("pop_cnt", pop_cnt, m_cnt[15:0]);
        chk("idle", idle, (occ == 0) && rempty);
        chk("rinc4", rinc4, e_rinc);
        chk("m_valid4", m_valid4, occ > 0);
        chk("m_data4", m_data4, e_data);
        chk("pop_cnt4", pop_cnt4, m_cnt[3:0]);
        if (m_valid && m_ready && rrst_n) dlv.push_back(m_data);
        run_len = rinc ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        pop_s = rinc;
        if (rrst_n) begin
            if (occ > 0 && m_ready) last_w = mq.pop_front();
            if (e_rinc) begin
                mq.push_back(rdata);
                m_cnt++;
            end
        end
    end

    initial begin
        rrst_n  = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        pop_s   = 1'b0;
        m_cnt   = 0;
        last_w  = 8'h00;
        run_len = 0;
        max_run = 0;
        load(8'h11, 8);

        // Reset held with data available
        cyc(3);
        chk("rst_rinc", rinc, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_pop_cnt", pop_cnt, 0);

        // Streaming at full rate
        rrst_n = 1'b1;
        cyc(12);
        chk("stream_pop_cnt", pop_cnt, 8);
        chk("stream_run", max_run, 8);
        chk("stream_idle", idle, 1);
        chk_dlv("stream_data", 8'h11, 8);

        // Backpressure: only two words may be pulled ahead
        m_ready = 1'b0;
        dlv.delete();
        load(8'hA0, 4);
        cyc(12);
        chk("bp_pop_cnt", pop_cnt, 10);
        chk("bp_rinc", rinc, 0);
        chk("bp_m_data", m_data, 8'hA0);
        m_ready = 1'b1;
        cyc(8);
        chk_dlv("bp_data", 8'hA0, 4);
        chk("bp_pop_cnt_end", pop_cnt, 12);

        // Enable pause after three pops, then resume
        dlv.delete();
        enable = 1'b0;
        load(8'hB0, 6);
        enable = 1'b1;
        cyc(3);
        enable = 1'b0;
        cyc(5);
        chk("en_pop_cnt", pop_cnt, 15);
        chk("en_rempty", rempty, 0);
        chk("en_dlv_count", dlv.size(), 3);
        enable = 1'b1;
        cyc(6);
        chk_dlv("en_data", 8'hB0, 6);
        chk("en_pop_cnt_end", pop_cnt, 18);

        // Permanently empty FIFO
        cyc(5);
        chk("empty_rinc", rinc, 0);
        chk("empty_m_valid", m_valid, 0);
        chk("empty_idle", idle, 1);

        // Counter wrap on the CNTW=4 instance
        rrst_n = 1'b0;
        cyc(1);
        load(8'h40, 18);
        dlv.delete();
        rrst_n = 1'b1;
        cyc(22);
        chk("wrap_pop_cnt4", pop_cnt4, 2);
        chk("wrap_pop_cnt", pop_cnt, 18);
        chk_dlv("wrap_data", 8'h40, 18);

        // Reset while two words are buffered
        m_ready = 1'b0;
        load(8'hC0, 5);
        cyc(4);
        chk("mid_m_valid_pre", m_valid, 1);
        chk("mid_rinc_pre", rinc, 0);
        rrst_n = 1'b0;
        #1;
        chk("mid_m_valid_rst", m_valid, 0);
        chk("mid_m_data_rst", m_data, 8'h00);
        cyc(2);
        dlv.delete();
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        cyc(6);
        chk_dlv("mid_data", 8'hC2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
